// File: rtl/reg_mux_select_if.sv
// Bundles the data, select and result signals of reg_mux_select.
// The slave modport is the selector block; master is whoever drives it.
interface reg_mux_select_if #(
    parameter int WIDTH = 1
);
    logic               en;
    logic [WIDTH-1:0]   i0;
    logic [WIDTH-1:0]   i1;
    logic               sel;
    logic [WIDTH-1:0]   i00;
    logic [WIDTH-1:0]   i01;
    logic [WIDTH-1:0]   i10;
    logic [WIDTH-1:0]   i11;
    logic               sel0;
    logic               sel1;
    logic [8*WIDTH-1:0] in8;
    logic [2:0]         sel8;
    logic [WIDTH-1:0]   out2;
    logic [WIDTH-1:0]   out4;
    logic [WIDTH-1:0]   out8;
    logic [WIDTH-1:0]   out2_q;
    logic [WIDTH-1:0]   out4_q;
    logic [WIDTH-1:0]   out8_q;

    modport slave (
        input  en, i0, i1, sel, i00, i01, i10, i11, sel0, sel1, in8, sel8,
        output out2, out4, out8, out2_q, out4_q, out8_q
    );

    modport master (
        output en, i0, i1, sel, i00, i01, i10, i11, sel0, sel1, in8, sel8,
        input  out2, out4, out8, out2_q, out4_q, out8_q
    );
endinterface

// File: rtl/reg_mux_select.sv
// Word-wide 2:1, 4:1 and 8:1 selectors, each with a combinational result
// for same-cycle reads and an enable-loaded registered copy for the pipeline.
module reg_mux_select #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    reg_mux_select_if.slave  bus
);

    // Single 2:1 slice; every wider selector is built out of these.
    function automatic logic [WIDTH-1:0] mux2(
        input logic             s,
        input logic [WIDTH-1:0] d0,
        input logic [WIDTH-1:0] d1
    );
        return s ? d1 : d0;
    endfunction

    // 4:1 slice as a tree of 2:1 slices; s[0] picks within a pair, s[1] between pairs.
    function automatic logic [WIDTH-1:0] mux4(
        input logic [1:0]       s,
        input logic [WIDTH-1:0] d0,
        input logic [WIDTH-1:0] d1,
        input logic [WIDTH-1:0] d2,
        input logic [WIDTH-1:0] d3
    );
        return mux2(s[1], mux2(s[0], d0, d1), mux2(s[0], d2, d3));
    endfunction

    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out4;
    logic [WIDTH-1:0] out8;
    logic [WIDTH-1:0] out8_lo;
    logic [WIDTH-1:0] out8_hi;

    logic [WIDTH-1:0] out2_d, out2_q;
    logic [WIDTH-1:0] out4_d, out4_q;
    logic [WIDTH-1:0] out8_d, out8_q;

    // Combinational selectors; the 8:1 is two 4:1 halves joined by a 2:1 on sel8[2].
    always_comb begin
        out2    = mux2(bus.sel, bus.i0, bus.i1);
        out4    = mux4({bus.sel1, bus.sel0}, bus.i00, bus.i01, bus.i10, bus.i11);
        out8_lo = mux4(bus.sel8[1:0],
                       bus.in8[0*WIDTH +: WIDTH], bus.in8[1*WIDTH +: WIDTH],
                       bus.in8[2*WIDTH +: WIDTH], bus.in8[3*WIDTH +: WIDTH]);
        out8_hi = mux4(bus.sel8[1:0],
                       bus.in8[4*WIDTH +: WIDTH], bus.in8[5*WIDTH +: WIDTH],
                       bus.in8[6*WIDTH +: WIDTH], bus.in8[7*WIDTH +: WIDTH]);
        out8    = mux2(bus.sel8[2], out8_lo, out8_hi);
    end

    // Next register values: load the live selector results when enabled, else hold.
    always_comb begin
        out2_d = out2_q;
        out4_d = out4_q;
        out8_d = out8_q;
        if (bus.en) begin
            out2_d = out2;
            out4_d = out4;
            out8_d = out8;
        end
    end

    // Pipeline copies; reset clears them and wins over the enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            out2_q <= '0;
            out4_q <= '0;
            out8_q <= '0;
        end else begin
            out2_q <= out2_d;
            out4_q <= out4_d;
            out8_q <= out8_d;
        end
    end

    assign bus.out2   = out2;
    assign bus.out4   = out4;
    assign bus.out8   = out8;
    assign bus.out2_q = out2_q;
    assign bus.out4_q = out4_q;
    assign bus.out8_q = out8_q;

endmodule

// File: tb/tb_reg_mux_select.sv
// Bench for reg_mux_select: directed sweeps on 1- and 8-bit instances,
// then randomized traffic on a 4-bit instance against a word-array model.
module tb_reg_mux_select;

    logic clk;
    logic reset;

    int n_cmp;
    int n_bad;

    reg_mux_select_if #(.WIDTH(1)) if1 ();
    reg_mux_select_if #(.WIDTH(8)) if8 ();
    reg_mux_select_if #(.WIDTH(4)) if4 ();

    reg_mux_select #(.WIDTH(1)) u_w1 (.clk(clk), .reset(reset), .bus(if1.slave));
    reg_mux_select #(.WIDTH(8)) u_w8 (.clk(clk), .reset(reset), .bus(if8.slave));
    reg_mux_select #(.WIDTH(4)) u_w4 (.clk(clk), .reset(reset), .bus(if4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges the run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state for the 4-bit instance.
    logic [3:0] m_q2, m_q4, m_q8;

    initial begin
        logic [7:0] pat8;
        logic [7:0] exp8;
        logic [3:0] exp4;
        logic [3:0] words8 [8];
        logic [3:0] words4 [4];
        logic [3:0] e2, e4, e8;

        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        {if1.en, if1.i0, if1.i1, if1.sel, if1.i00, if1.i01, if1.i10, if1.i11,
         if1.sel0, if1.sel1, if1.in8, if1.sel8} = '0;
        {if8.en, if8.i0, if8.i1, if8.sel, if8.i00, if8.i01, if8.i10, if8.i11,
         if8.sel0, if8.sel1, if8.in8, if8.sel8} = '0;
        {if4.en, if4.i0, if4.i1, if4.sel, if4.i00, if4.i01, if4.i10, if4.i11,
         if4.sel0, if4.sel1, if4.in8, if4.sel8} = '0;
        tick();

        // 8:1 sweep, single-bit words.
        pat8 = 8'b01101110;
        exp8 = 8'b01101110;
        if1.in8 = pat8;
        for (int k = 0; k < 8; k++) begin
            if1.sel8 = 3'(k);
            #1;
            chk($sformatf("w1_out8_sel%0d", k), 64'(if1.out8), 64'(exp8[k]));
        end

        // 4:1 sweep; index is {sel1,sel0}.
        if1.i00 = 1'b0; if1.i01 = 1'b1; if1.i10 = 1'b1; if1.i11 = 1'b0;
        exp4 = 4'b0110;
        for (int k = 0; k < 4; k++) begin
            {if1.sel1, if1.sel0} = 2'(k);
            #1;
            chk($sformatf("w1_out4_sel%0d", k), 64'(if1.out4), 64'(exp4[k]));
        end
        // sel0=1, sel1=0 must pick i01: make i01 and i10 differ in the other direction too.
        if1.i01 = 1'b0; if1.i10 = 1'b1; if1.sel1 = 1'b0; if1.sel0 = 1'b1;
        #1;
        chk("w1_out4_i01_not_i10", 64'(if1.out4), 64'(0));

        // 2:1 exhaustive.
        for (int k = 0; k < 8; k++) begin
            logic [2:0] v;
            v = 3'(k);
            if1.i0 = v[0]; if1.i1 = v[1]; if1.sel = v[2];
            #1;
            chk($sformatf("w1_out2_%0d", k), 64'(if1.out2), 64'(v[2] ? v[1] : v[0]));
        end

        // Registered 8:1 path, 8-bit words 0x10..0x17.
        reset = 1'b1;
        if8.en = 1'b1;
        for (int k = 0; k < 8; k++) if8.in8[k*8 +: 8] = 8'(8'h10 + k);
        if8.sel8 = 3'd5;
        tick();
        chk("w8_out8_q_reset", 64'(if8.out8_q), 64'h0);
        chk("w8_out8_during_reset", 64'(if8.out8), 64'h15);
        reset = 1'b0;
        tick();
        chk("w8_out8_q_load", 64'(if8.out8_q), 64'h15);
        if8.en = 1'b0;
        if8.sel8 = 3'd2;
        #1;
        chk("w8_out8_comb_sel2", 64'(if8.out8), 64'h12);
        tick();
        chk("w8_out8_q_hold", 64'(if8.out8_q), 64'h15);

        // Reset wins over enable.
        if8.en = 1'b1; reset = 1'b1; if8.i1 = 8'hAA; if8.sel = 1'b1;
        tick();
        chk("w8_out2_q_rst_prio", 64'(if8.out2_q), 64'h0);
        chk("w8_out2_comb_in_rst", 64'(if8.out2), 64'hAA);
        reset = 1'b0;
        tick();
        chk("w8_out2_q_after_rst", 64'(if8.out2_q), 64'hAA);

        // Randomized run on the 4-bit instance.
        m_q2 = '0; m_q4 = '0; m_q8 = '0;
        for (int c = 0; c < 200; c++) begin
            reset    = (c == 0) ? 1'b1 : ($urandom_range(0, 15) == 0);
            if4.en   = 1'($urandom);
            if4.i0   = 4'($urandom); if4.i1 = 4'($urandom); if4.sel = 1'($urandom);
            if4.i00  = 4'($urandom); if4.i01 = 4'($urandom);
            if4.i10  = 4'($urandom); if4.i11 = 4'($urandom);
            if4.sel0 = 1'($urandom); if4.sel1 = 1'($urandom);
            if4.in8  = 32'($urandom);
            if4.sel8 = 3'($urandom);
            #1;

            for (int k = 0; k < 8; k++) words8[k] = if4.in8[k*4 +: 4];
            words4[0] = if4.i00; words4[1] = if4.i01;
            words4[2] = if4.i10; words4[3] = if4.i11;
            e2 = if4.sel ? if4.i1 : if4.i0;
            e4 = words4[int'(if4.sel1) * 2 + int'(if4.sel0)];
            e8 = words8[int'(if4.sel8)];

            chk("rnd_out2", 64'(if4.out2), 64'(e2));
            chk("rnd_out4", 64'(if4.out4), 64'(e4));
            chk("rnd_out8", 64'(if4.out8), 64'(e8));

            if (reset) begin
                m_q2 = '0; m_q4 = '0; m_q8 = '0;
            end else if (if4.en) begin
                m_q2 = e2; m_q4 = e4; m_q8 = e8;
            end

            tick();
            chk("rnd_out2_q", 64'(if4.out2_q), 64'(m_q2));
            chk("rnd_out4_q", 64'(if4.out4_q), 64'(m_q4));
            chk("rnd_out8_q", 64'(if4.out8_q), 64'(m_q8));
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
